serial_adder_v: RTL and testbench
=================================

Name: serial_adder_v

Overview:
- Bit-serial adder: one `full_adder_v` instance plus a registered carry feedback loop.
- Adds two WIDTH-bit operands LSB-first, one bit per clock.
- Sits around the combinational full adder: feeds it operand bits and consumes its sum/carry outputs each cycle.
- Area-cheap alternative to a ripple chain; start/done handshake toward a controlling block.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
- i_clk  input  1  clock; all state updates on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_start  input  1  request to begin an addition; sampled only in IDLE
- i_a  input  WIDTH  operand A; captured on the accepted start edge
- i_b  input  WIDTH  operand B; captured on the accepted start edge
- i_carry  input  1  carry-in; captured on the accepted start edge
- o_busy  output  1  high in SHIFT and DONE; low only in IDLE
- o_done  output  1  single-cycle pulse; result valid
- o_sum  output  WIDTH  registered sum; held until the next result
- o_carry  output  1  registered carry-out; held until the next result

Behaviour:
- Interface: one clock `i_clk`. Reset `i_rst_n` is asynchronous and active-low.
- Reset (asserted at any time, including mid-operation):
  - State returns to IDLE; the operation in progress is abandoned, with no partial result.
  - o_busy=0, o_done=0, o_sum=0, o_carry=0.
  - Internal shift registers, carry register and bit counter cleared.
- FSM states and transitions:
  - IDLE -> SHIFT on an edge with i_start=1.
  - SHIFT -> DONE after WIDTH processed bits.
  - DONE -> IDLE unconditionally after one cycle.
- Start edge E0 (IDLE, i_start=1):
  - A_sr<=i_a, B_sr<=i_b, c_reg<=i_carry, cnt<=0, state<=SHIFT.
- Each SHIFT edge Ek, k=1..WIDTH:
  - The full adder sees (A_sr[0], B_sr[0], c_reg).
  - c_reg<=adder carry.
  - The sum bit shifts into the MSB of S_sr; S_sr, A_sr and B_sr shift right by 1.
  - cnt<=cnt+1.
- At edge E_WIDTH (cnt==WIDTH-1):
  - o_sum<= final S_sr value, with LSB-first ordering yielding the correct bit positions.
  - o_carry<= final adder carry.
  - state<=DONE.
- DONE cycle: o_done=1 for exactly one cycle.
- Edge E_WIDTH+1: state<=IDLE, o_done=0.
- Latency: o_done is high in the cycle following E_WIDTH, i.e. WIDTH+1 edges after the start was sampled. Minimum start-to-start spacing is WIDTH+2 cycles.
- o_sum/o_carry:
  - Change only at E_WIDTH (or on reset).
  - Stable during SHIFT, DONE and IDLE.
- i_start while o_busy=1 (SHIFT or DONE): ignored. No queueing; the operands at that time are not captured.
- i_a/i_b/i_carry changing after E0 have no effect on the operation in progress.
- Arithmetic: {o_carry,o_sum} = i_a + i_b + i_carry, unsigned, (WIDTH+1)-bit exact; overflow is reported only via o_carry.
- cnt width is $clog2(WIDTH). cnt does not wrap before the DONE transition.
- o_done and o_busy are registered, or decoded from registered state only; there is no combinational path from i_start.

Test Plan:
- WIDTH=8, reset low 3 cycles then release -> o_sum=0x00, o_carry=0, o_busy=0, o_done=0; no activity without i_start.
- i_a=0x3C, i_b=0x5A, i_carry=0, 1-cycle i_start -> o_busy high next cycle; o_done pulses exactly once, 9 edges after start; o_sum=0x96, o_carry=0.
- i_a=0xFF, i_b=0x01, i_carry=0 -> o_sum=0x00, o_carry=1. Then i_a=0xFF, i_b=0xFF, i_carry=1 -> o_sum=0xFF, o_carry=1.
- Start 0x10+0x20; during SHIFT pulse i_start with 0xAA+0x55 and change i_a/i_b -> only one o_done; o_sum=0x30. Start held high through DONE -> new operation begins only from IDLE.
- Start 0x7F+0x01, assert i_rst_n=0 asynchronously at edge 4 -> outputs clear immediately with no o_done. After release, a fresh 0x7F+0x01 gives o_sum=0x80, o_carry=0.
- Back-to-back: second i_start in the first IDLE cycle after DONE, 0x01+0x01, i_carry=1 -> o_sum=0x03. The prior result is held until that E_WIDTH.

Source files
------------

// File: rtl/serial_adder_v.sv
`default_nettype none

// ============================================================================
//  Module   : full_adder_v
//  Purpose  : Single-bit combinational full adder.
//  Ports    : i_a, i_b, i_cin  - addend bits and carry-in
//             o_sum, o_cout    - sum bit and carry-out
//  Revision : 1.0 - initial release
// ============================================================================
module full_adder_v (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule

// ============================================================================
//  Module   : serial_adder_v
//  Purpose  : Bit-serial adder. One full adder with a registered carry loop
//             adds two WIDTH-bit operands LSB-first, one bit per clock.
//             {o_carry, o_sum} = i_a + i_b + i_carry.
//  Ports    : i_clk    - clock, rising edge
//             i_rst_n  - asynchronous active-low reset
//             i_start  - begin an addition (only honoured in IDLE)
//             i_a/i_b  - operands, captured on the accepted start edge
//             i_carry  - carry-in, captured on the accepted start edge
//             o_busy   - high while SHIFT or DONE
//             o_done   - one-cycle pulse, result valid
//             o_sum    - registered sum, held until the next result
//             o_carry  - registered carry-out, held until the next result
//  Revision : 1.0 - initial release
// ============================================================================
module serial_adder_v #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_carry,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);

    localparam int                 c_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    // Only WIDTH-1 sum bits need storing: the final bit comes straight from
    // the adder on the last shift edge and is merged into w_s_next.
    logic [WIDTH-2:0]   r_s_sr;
    logic               r_c;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_sum;
    logic               r_carry_out;

    logic               w_sum_bit;
    logic               w_cout;
    logic [WIDTH-1:0]   w_s_next;
    logic               w_accept;
    logic               w_last;

    full_adder_v u_fa (
        .i_a    (r_a_sr[0]),
        .i_b    (r_b_sr[0]),
        .i_cin  (r_c),
        .o_sum  (w_sum_bit),
        .o_cout (w_cout)
    );

    // Sum bits enter at the MSB and walk down, so after WIDTH shifts the
    // first (LSB) sum bit has arrived at position 0.
    assign w_s_next = {w_sum_bit, r_s_sr};
    assign w_accept = (r_state == ST_IDLE) && i_start;
    assign w_last   = (r_state == ST_SHIFT) && (r_cnt == c_CNT_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_state_next = ST_SHIFT;
            ST_SHIFT: if (r_cnt == c_CNT_LAST) w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand/sum shift registers, carry loop, bit counter
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a_sr      <= '0;
            r_b_sr      <= '0;
            r_s_sr      <= '0;
            r_c         <= 1'b0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_carry_out <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a_sr <= i_a;
                r_b_sr <= i_b;
                r_c    <= i_carry;
                r_cnt  <= '0;
            end else if (r_state == ST_SHIFT) begin
                r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
                r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
                r_s_sr <= w_s_next[WIDTH-1:1];
                r_c    <= w_cout;
                // Counter parks on the last value so it never wraps.
                if (!w_last) begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
            end

            if (w_last) begin
                r_sum       <= w_s_next;
                r_carry_out <= w_cout;
            end
        end
    end

    // Status outputs decode registered state only.
    assign o_busy  = (r_state != ST_IDLE);
    assign o_done  = (r_state == ST_DONE);
    assign o_sum   = r_sum;
    assign o_carry = r_carry_out;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_v.sv
`default_nettype none

// ============================================================================
//  Module   : tb_serial_adder_v
//  Purpose  : Self-checking bench for serial_adder_v (WIDTH=8). Directed
//             vectors push expected {carry,sum} and completion cycle into a
//             scoreboard queue; a monitor pops and compares on every o_done.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder_v;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         carry = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    typedef struct {
        logic [W:0] res;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    serial_adder_v #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_a     (a),
        .i_b     (b),
        .i_carry (carry),
        .o_busy  (busy),
        .o_done  (done),
        .o_sum   (sum),
        .o_carry (cout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: actual done at cycle %0d required none", cyc);
            end else begin
                e = q.pop_front();
                check("result", {23'b0, cout, sum}, {23'b0, e.res});
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    // One-cycle start pulse issued at a falling edge; c0 is the cycle count
    // before the accepting edge, so done is expected at c0+W+1.
    task automatic start_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                            input logic vc, input logic [W:0] res, output int c0);
        exp_t e;
        @(negedge clk);
        a     = va;
        b     = vb;
        carry = vc;
        start = 1'b1;
        c0    = cyc;
        e.res = res;
        e.cyc = c0 + W + 1;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {31'b0, busy}, 32'd1);
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, {31'b0, seen}, 32'd1);
    endtask

    initial begin
        int c0;
        exp_t e;

        // Reset
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_sum",   {24'b0, sum},  32'h0);
        check("rst_carry", {31'b0, cout}, 32'h0);
        check("rst_busy",  {31'b0, busy}, 32'h0);
        check("rst_done",  {31'b0, done}, 32'h0);
        repeat (5) @(negedge clk);
        check("idle_no_start", {31'b0, busy}, 32'h0);

        // Basic additions
        start_op(8'h3C, 8'h5A, 1'b0, 9'h096, c0);
        wait_done("done_3c_5a");
        start_op(8'hFF, 8'h01, 1'b0, 9'h100, c0);
        wait_done("done_ff_01");
        start_op(8'hFF, 8'hFF, 1'b1, 9'h1FF, c0);
        wait_done("done_ff_ff_1");

        // Start and operand changes during SHIFT are ignored
        start_op(8'h10, 8'h20, 1'b0, 9'h030, c0);
        @(negedge clk);
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        check("sum_held_shift", {24'b0, sum}, 32'hFF);
        @(negedge clk);
        start = 1'b0;
        a     = 8'h33;
        b     = 8'h44;
        carry = 1'b1;
        wait_done("done_10_20");

        // Start held high through DONE: second op only starts from IDLE
        @(negedge clk);
        c0    = cyc;
        a     = 8'h11;
        b     = 8'h22;
        carry = 1'b0;
        start = 1'b1;
        e.res = 9'h033; e.cyc = c0 + W + 1;  q.push_back(e);
        e.res = 9'h00B; e.cyc = c0 + 2*W + 3; q.push_back(e);
        @(negedge clk);
        a = 8'h05;
        b = 8'h06;
        while (cyc < c0 + W + 3) @(negedge clk);
        start = 1'b0;
        wait_done("done_hold_second");

        // Asynchronous reset in the middle of an operation
        start_op(8'h7F, 8'h01, 1'b0, 9'h080, c0);
        while (cyc < c0 + 4) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        check("midrst_busy", {31'b0, busy}, 32'h0);
        check("midrst_done", {31'b0, done}, 32'h0);
        check("midrst_sum",  {24'b0, sum},  32'h0);
        check("midrst_carry", {31'b0, cout}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("postrst_idle", {31'b0, busy}, 32'h0);
        start_op(8'h7F, 8'h01, 1'b0, 9'h080, c0);
        wait_done("done_7f_01");

        // Back-to-back: new start in the first IDLE cycle after DONE
        start_op(8'hC8, 8'h64, 1'b0, 9'h12C, c0);
        wait_done("done_c8_64");
        start_op(8'h01, 8'h01, 1'b1, 9'h003, c0);
        repeat (7) @(negedge clk);
        check("b2b_sum_held",   {24'b0, sum},  32'h2C);
        check("b2b_carry_held", {31'b0, cout}, 32'h1);
        wait_done("done_b2b");

        repeat (3) @(negedge clk);
        check("queue_empty", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
